csi_ppi_packet_decoder: RTL and testbench
=========================================

# csi_ppi_packet_decoder

Receive-side CSI-2 packet decoder that consumes the D-PHY PPI high-speed byte stream, four lanes at gear 8. It sits directly behind the D-PHY RX, on the PPI outputs `rx_valid_hs`/`rx_data_hs`. It extracts and ECC-checks each packet header, and emits short-packet events and long-packet payload as 32-bit beats. Packet trailer bytes are discarded up to the end of HS transmission.

## Interface
- `MIPI_LANES`, 4: number of lanes; only 4 is supported.
- `MIPI_GEAR`, 8: bits per lane per byte-clock; only 8 is supported.
- `clk_i`  in  1  byte clock; same net as `rx_byte_clk_hs`.
- `reset_i`  in  1  reset; one clock, reset asynchronous and active-high.
- `rx_valid_hs_i`  in  [MIPI_LANES]  per-lane HS valid.
- `rx_data_hs_i`  in  [MIPI_LANES][MIPI_GEAR]  per-lane HS byte.
- `header_valid_o`  out  1  one-cycle pulse; header accepted.
- `short_pkt_o`  out  1  qualifies `header_valid_o`; high when the data type is less than 0x10.
- `data_id_o`  out  8  {VC[1:0], DT[5:0]} of the last accepted header.
- `word_count_o`  out  16  WC (long packet) or data field (short packet).
- `payload_valid_o`  out  1  payload beat valid.
- `payload_data_o`  out  32  payload bytes; first wire byte in [7:0].
- `payload_byte_en_o`  out  4  valid-byte mask of the beat.
- `payload_last_o`  out  1  final beat of the packet.
- `frame_active_o`  out  1  high between an accepted FS and an accepted FE.
- `err_ecc_o`  out  1  pulse; header ECC mismatch.
- `err_lane_align_o`  out  1  pulse; lanes not valid together at SoT.
- `err_truncated_o`  out  1  pulse; valid dropped before WC bytes were received.

## Operation
- **Lane order within a cycle:** lane 3 carries the first byte, then lane 2, lane 1, lane 0.
- **Header cycle:**
  - lane3 = DataID;
  - lane2 = WC[7:0];
  - lane1 = WC[15:8];
  - lane0 = ECC.
  - The ECC is the CSI-2 6-bit Hamming code over D = {WC[15:8], WC[7:0], DataID}. It is compared against ECC[5:0]; ECC[7:6] are ignored. No correction is performed.
- **FSM states: IDLE, PAYLOAD, DRAIN.**
- **IDLE:**
  - All four valids high → evaluate the header on that cycle.
    - ECC bad → pulse `err_ecc_o`, go to DRAIN.
    - Short packet (DT<0x10) → pulse `header_valid_o` with `short_pkt_o`=1, go to DRAIN.
      - DT 0x00 (FS) sets `frame_active_o`; DT 0x01 (FE) clears it.
      - Other short DTs are reported only.
    - Long packet with WC=0 → header pulse, go to DRAIN.
    - Long packet with WC>0 → header pulse, load the remaining-byte counter with WC, go to PAYLOAD.
  - Some but not all valids high → pulse `err_lane_align_o` once, go to DRAIN.
- **PAYLOAD:**
  - Each cycle with all valids high emits one beat and subtracts 4 from the counter (16-bit, no wrap).
  - When remaining ≤4, the beat's byte_en is the low `remaining` bits set (1→0x1, 2→0x3, 3→0x7, 4→0xF), `payload_last_o`=1, go to DRAIN.
  - Any valid low → pulse `err_truncated_o`, no beat, go to IDLE.
- **DRAIN:** ignore data (CRC and filler bytes are not checked) until all valids are low, then go to IDLE. A new header needs at least one all-low cycle first.
- **Reset mid-operation:** FSM → IDLE and all outputs → 0, including `frame_active_o`. The packet in flight is dropped silently.

## Timing
- All outputs are registered; latency is 1 cycle from the input sample to the output.
- Pulses and `payload_valid_o` last exactly one cycle per event. There is no ready/backpressure; the downstream must accept every beat.
- `data_id_o`/`word_count_o` hold until the next accepted header.
- `payload_data_o`/`payload_byte_en_o` are 0 when not valid.
- Reset values: every output is 0.
- **Error priority on a header cycle:** alignment error over ECC error. An ECC failure produces no `header_valid_o`.
- **Payload beat timing:** the first beat appears 1 cycle after the header pulse, i.e. 2 cycles after the header input. A WC-byte packet then produces ceil(WC/4) beats on consecutive cycles when the input is contiguous.

## Structure
- Shared package `csi_pkg` holds:
  - DT constants (FSC=0x00, FEC=0x01, LSC=0x02, LEC=0x03, RAW8=0x2A, RAW10=0x2B);
  - a `csi_header_t` struct (data_id, word_count, ecc);
  - the short/long DT threshold 0x10.
- One sub-module, `csi_ecc_calc`: combinational, 24-bit D in, 6-bit ECC out. It is reused by the TX side.

## Test plan
- **FS short packet:** DataID 0x00, WC 0x0000, ECC 0x00, then three 0xFF filler cycles, valids low → `header_valid_o`=1, `short_pkt_o`=1, `frame_active_o` rises. The three filler cycles produce no further events. Then FE (0x01, ECC 0x07) → `frame_active_o` falls.
- **RAW8 line, full beats:** DataID 0x2A, WC 512, correct ECC, then 128 payload beats and 20 cycles of 0xFF → 128 beats, all byte_en 0xF. `payload_last_o` is set on beat 128. The 0xFF bytes are never output.
- **Partial last beat:** RAW10 DataID 0x2B, WC 6, bytes 01..06 → beat1 = 0x04030201 with byte_en 0xF; beat2 = 0x00000605 with byte_en 0x3 and last=1.
- **ECC error:** ECC bit 3 flipped on a WC=512 header → only `err_ecc_o` pulses. There is no header pulse and no payload. The next valid packet decodes normally.
- **Truncation:** WC 512, valids dropped after 10 beats → 10 beats and one `err_truncated_o` pulse, with no `payload_last_o`.
- **Misalignment and reset:** lane 0 valid asserted one cycle late → one `err_lane_align_o` pulse. Separately, `reset_i` asserted mid-payload → all outputs 0 immediately and a clean decode after release.

Source files
------------

// File: rtl/csi_pkg.sv
// Shared CSI-2 definitions: data types, packet header layout and decoder state encoding.
package csi_pkg;

  localparam int unsigned BEAT_BYTES = 4;
  localparam int unsigned WC_W       = 16;

  localparam logic [5:0] DT_FSC      = 6'h00;
  localparam logic [5:0] DT_FEC      = 6'h01;
  localparam logic [5:0] DT_LSC      = 6'h02;
  localparam logic [5:0] DT_LEC      = 6'h03;
  localparam logic [5:0] DT_RAW8     = 6'h2A;
  localparam logic [5:0] DT_RAW10    = 6'h2B;
  localparam logic [5:0] DT_LONG_MIN = 6'h10;

  typedef struct packed {
    logic [7:0]      data_id;
    logic [WC_W-1:0] word_count;
    logic [7:0]      ecc;
  } csi_header_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PAYLOAD,
    ST_DRAIN
  } dec_state_t;

  // Byte-enable mask for a final beat holding 1..4 remaining bytes.
  function automatic logic [BEAT_BYTES-1:0] tail_byte_en(input logic [2:0] n);
    case (n)
      3'd1:    tail_byte_en = 4'h1;
      3'd2:    tail_byte_en = 4'h3;
      3'd3:    tail_byte_en = 4'h7;
      default: tail_byte_en = 4'hF;
    endcase
  endfunction

endpackage

// File: rtl/csi_ecc_calc.sv
// CSI-2 packet header Hamming code: 24 data bits {WC[15:8], WC[7:0], DataID} to 6 parity bits.
module csi_ecc_calc (
  input  logic [23:0] d,
  output logic [5:0]  ecc
);

  always_comb begin
    ecc[0] = ^{d[0], d[1], d[2], d[4], d[5], d[7], d[10], d[11], d[13], d[16],
               d[20], d[21], d[22], d[23]};
    ecc[1] = ^{d[0], d[1], d[3], d[4], d[6], d[8], d[10], d[12], d[14], d[17],
               d[20], d[21], d[22], d[23]};
    ecc[2] = ^{d[0], d[2], d[3], d[5], d[6], d[9], d[11], d[12], d[15], d[18],
               d[20], d[21], d[22]};
    ecc[3] = ^{d[1], d[2], d[3], d[7], d[8], d[9], d[13], d[14], d[15], d[19],
               d[20], d[21], d[23]};
    ecc[4] = ^{d[4], d[5], d[6], d[7], d[8], d[9], d[16], d[17], d[18], d[19],
               d[20], d[22], d[23]};
    ecc[5] = ^{d[10], d[11], d[12], d[13], d[14], d[15], d[16], d[17], d[18], d[19],
               d[21], d[22], d[23]};
  end

endmodule

// File: rtl/csi_ppi_packet_decoder.sv
// CSI-2 RX packet decoder on a 4-lane gear-8 PPI byte stream: header ECC check,
// short-packet events, and long-packet payload as 32-bit beats.
module csi_ppi_packet_decoder
  import csi_pkg::*;
#(
  parameter int unsigned MIPI_LANES = 4,
  parameter int unsigned MIPI_GEAR  = 8
) (
  input  logic                                  clk_i,
  input  logic                                  reset_i,
  input  logic [MIPI_LANES-1:0]                 rx_valid_hs_i,
  input  logic [MIPI_LANES-1:0][MIPI_GEAR-1:0]  rx_data_hs_i,
  output logic                                  header_valid_o,
  output logic                                  short_pkt_o,
  output logic [7:0]                            data_id_o,
  output logic [15:0]                           word_count_o,
  output logic                                  payload_valid_o,
  output logic [31:0]                           payload_data_o,
  output logic [3:0]                            payload_byte_en_o,
  output logic                                  payload_last_o,
  output logic                                  frame_active_o,
  output logic                                  err_ecc_o,
  output logic                                  err_lane_align_o,
  output logic                                  err_truncated_o
);

  dec_state_t  state_q, state_d;
  logic [15:0] remaining_q, remaining_d;

  logic        header_valid_q, header_valid_d;
  logic        short_pkt_q, short_pkt_d;
  logic [7:0]  data_id_q, data_id_d;
  logic [15:0] word_count_q, word_count_d;
  logic        payload_valid_q, payload_valid_d;
  logic [31:0] payload_data_q, payload_data_d;
  logic [3:0]  byte_en_q, byte_en_d;
  logic        last_q, last_d;
  logic        frame_active_q, frame_active_d;
  logic        err_ecc_q, err_ecc_d;
  logic        err_align_q, err_align_d;
  logic        err_trunc_q, err_trunc_d;

  logic        all_valid, any_valid;
  csi_header_t hdr;
  logic [5:0]  ecc_calc;
  logic        ecc_ok;
  logic [31:0] beat_data;
  logic        unused_ecc_hi;

  assign all_valid = &rx_valid_hs_i;
  assign any_valid = |rx_valid_hs_i;

  // Lane 3 carries the first wire byte of each cycle.
  assign hdr = '{data_id:    rx_data_hs_i[3],
                 word_count: {rx_data_hs_i[1], rx_data_hs_i[2]},
                 ecc:        rx_data_hs_i[0]};
  assign beat_data = {rx_data_hs_i[0], rx_data_hs_i[1], rx_data_hs_i[2], rx_data_hs_i[3]};

  csi_ecc_calc u_ecc (
    .d   ({hdr.word_count, hdr.data_id}),
    .ecc (ecc_calc)
  );

  assign ecc_ok        = (ecc_calc == hdr.ecc[5:0]);
  assign unused_ecc_hi = ^hdr.ecc[7:6];

  // Next-state and next-output decode.
  always_comb begin
    state_d         = state_q;
    remaining_d     = remaining_q;
    header_valid_d  = 1'b0;
    short_pkt_d     = 1'b0;
    data_id_d       = data_id_q;
    word_count_d    = word_count_q;
    payload_valid_d = 1'b0;
    payload_data_d  = '0;
    byte_en_d       = '0;
    last_d          = 1'b0;
    frame_active_d  = frame_active_q;
    err_ecc_d       = 1'b0;
    err_align_d     = 1'b0;
    err_trunc_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (all_valid) begin
          state_d = ST_DRAIN;
          if (!ecc_ok) begin
            err_ecc_d = 1'b1;
          end else begin
            header_valid_d = 1'b1;
            data_id_d      = hdr.data_id;
            word_count_d   = hdr.word_count;
            if (hdr.data_id[5:0] < DT_LONG_MIN) begin
              short_pkt_d = 1'b1;
              if (hdr.data_id[5:0] == DT_FSC)      frame_active_d = 1'b1;
              else if (hdr.data_id[5:0] == DT_FEC) frame_active_d = 1'b0;
            end else if (hdr.word_count != 16'd0) begin
              remaining_d = hdr.word_count;
              state_d     = ST_PAYLOAD;
            end
          end
        end else if (any_valid) begin
          err_align_d = 1'b1;
          state_d     = ST_DRAIN;
        end
      end

      ST_PAYLOAD: begin
        if (all_valid) begin
          payload_valid_d = 1'b1;
          if (remaining_q <= 16'd4) begin
            byte_en_d   = tail_byte_en(remaining_q[2:0]);
            last_d      = 1'b1;
            remaining_d = '0;
            state_d     = ST_DRAIN;
          end else begin
            byte_en_d   = 4'hF;
            remaining_d = remaining_q - 16'd4;
          end
          for (int i = 0; i < 4; i++) begin
            payload_data_d[8*i +: 8] = byte_en_d[i] ? beat_data[8*i +: 8] : 8'h00;
          end
        end else begin
          err_trunc_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end

      ST_DRAIN: begin
        if (!any_valid) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q         <= ST_IDLE;
      remaining_q     <= '0;
      header_valid_q  <= 1'b0;
      short_pkt_q     <= 1'b0;
      data_id_q       <= '0;
      word_count_q    <= '0;
      payload_valid_q <= 1'b0;
      payload_data_q  <= '0;
      byte_en_q       <= '0;
      last_q          <= 1'b0;
      frame_active_q  <= 1'b0;
      err_ecc_q       <= 1'b0;
      err_align_q     <= 1'b0;
      err_trunc_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      remaining_q     <= remaining_d;
      header_valid_q  <= header_valid_d;
      short_pkt_q     <= short_pkt_d;
      data_id_q       <= data_id_d;
      word_count_q    <= word_count_d;
      payload_valid_q <= payload_valid_d;
      payload_data_q  <= payload_data_d;
      byte_en_q       <= byte_en_d;
      last_q          <= last_d;
      frame_active_q  <= frame_active_d;
      err_ecc_q       <= err_ecc_d;
      err_align_q     <= err_align_d;
      err_trunc_q     <= err_trunc_d;
    end
  end

  assign header_valid_o    = header_valid_q;
  assign short_pkt_o       = short_pkt_q;
  assign data_id_o         = data_id_q;
  assign word_count_o      = word_count_q;
  assign payload_valid_o   = payload_valid_q;
  assign payload_data_o    = payload_data_q;
  assign payload_byte_en_o = byte_en_q;
  assign payload_last_o    = last_q;
  assign frame_active_o    = frame_active_q;
  assign err_ecc_o         = err_ecc_q;
  assign err_lane_align_o  = err_align_q;
  assign err_truncated_o   = err_trunc_q;

endmodule

// File: tb/tb_csi_ppi_packet_decoder.sv
// Bench for csi_ppi_packet_decoder: directed and random packets against an event-list reference model.
module tb_csi_ppi_packet_decoder;
  import csi_pkg::*;

  typedef logic [7:0] byte_q_t[$];

  typedef struct packed {
    logic [2:0]  kind;
    logic        short_pkt;
    logic [7:0]  id;
    logic [15:0] wc;
    logic [31:0] data;
    logic [3:0]  en;
    logic        last;
  } ev_t;

  localparam logic [2:0] EV_HDR = 3'd1, EV_BEAT = 3'd2, EV_ECC = 3'd3,
                         EV_ALIGN = 3'd4, EV_TRUNC = 3'd5, EV_JUNK = 3'd6;

  logic              clk_i = 1'b0;
  logic              reset_i;
  logic [3:0]        rx_valid_hs_i;
  logic [3:0][7:0]   rx_data_hs_i;
  logic              header_valid_o, short_pkt_o;
  logic [7:0]        data_id_o;
  logic [15:0]       word_count_o;
  logic              payload_valid_o;
  logic [31:0]       payload_data_o;
  logic [3:0]        payload_byte_en_o;
  logic              payload_last_o, frame_active_o;
  logic              err_ecc_o, err_lane_align_o, err_truncated_o;

  ev_t  obs_q[$], exp_q[$];
  ev_t  mon_e;
  int   n_vec = 0, n_err = 0;
  logic exp_frame = 1'b0;
  logic [7:0]  last_id = '0;
  logic [15:0] last_wc = '0;

  always #5 clk_i = ~clk_i;

  csi_ppi_packet_decoder #(.MIPI_LANES(4), .MIPI_GEAR(8)) dut (
    .clk_i             (clk_i),
    .reset_i           (reset_i),
    .rx_valid_hs_i     (rx_valid_hs_i),
    .rx_data_hs_i      (rx_data_hs_i),
    .header_valid_o    (header_valid_o),
    .short_pkt_o       (short_pkt_o),
    .data_id_o         (data_id_o),
    .word_count_o      (word_count_o),
    .payload_valid_o   (payload_valid_o),
    .payload_data_o    (payload_data_o),
    .payload_byte_en_o (payload_byte_en_o),
    .payload_last_o    (payload_last_o),
    .frame_active_o    (frame_active_o),
    .err_ecc_o         (err_ecc_o),
    .err_lane_align_o  (err_lane_align_o),
    .err_truncated_o   (err_truncated_o)
  );

  // Every output pulse becomes one event; stray payload fields outside a beat are junk events.
  always @(negedge clk_i) begin
    if (!reset_i) begin
      if (header_valid_o) begin
        mon_e = '0; mon_e.kind = EV_HDR; mon_e.short_pkt = short_pkt_o;
        mon_e.id = data_id_o; mon_e.wc = word_count_o; obs_q.push_back(mon_e);
      end
      if (payload_valid_o) begin
        mon_e = '0; mon_e.kind = EV_BEAT; mon_e.data = payload_data_o;
        mon_e.en = payload_byte_en_o; mon_e.last = payload_last_o; obs_q.push_back(mon_e);
      end else if (payload_data_o != '0 || payload_byte_en_o != '0 || payload_last_o) begin
        mon_e = '0; mon_e.kind = EV_JUNK; mon_e.data = payload_data_o;
        mon_e.en = payload_byte_en_o; mon_e.last = payload_last_o; obs_q.push_back(mon_e);
      end
      if (err_ecc_o)        begin mon_e = '0; mon_e.kind = EV_ECC;   obs_q.push_back(mon_e); end
      if (err_lane_align_o) begin mon_e = '0; mon_e.kind = EV_ALIGN; obs_q.push_back(mon_e); end
      if (err_truncated_o)  begin mon_e = '0; mon_e.kind = EV_TRUNC; obs_q.push_back(mon_e); end
    end
  end

  // Parity column of each header data bit; the ECC is the XOR of the columns of the set bits.
  function automatic logic [5:0] ref_ecc(input logic [23:0] d);
    logic [5:0] col [24] = '{6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
                             6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
                             6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B};
    logic [5:0] p = '0;
    for (int i = 0; i < 24; i++) if (d[i]) p ^= col[i];
    return p;
  endfunction

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i); #1;
      rx_valid_hs_i = '0;
      rx_data_hs_i  = '0;
    end
  endtask

  // Drive header + body bytes (padded with 0xFF to whole cycles) and queue the expected events.
  task automatic send_pkt(input logic [7:0] id, input logic [15:0] wc, input logic [7:0] flip,
                          input byte_q_t body, input int gap);
    logic [7:0] ecc8, wb;
    int ncyc, need;
    ev_t e;
    ecc8 = {2'b00, ref_ecc({wc, id})} ^ flip;
    ncyc = (body.size() + 3) / 4;
    @(posedge clk_i); #1;
    rx_valid_hs_i = 4'hF;
    rx_data_hs_i  = {id, wc[7:0], wc[15:8], ecc8};
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk_i); #1;
      for (int k = 0; k < 4; k++)
        rx_data_hs_i[3-k] = (4*c + k < body.size()) ? body[4*c + k] : 8'hFF;
    end
    idle_cycles(gap);

    if (ref_ecc({wc, id}) != ecc8[5:0]) begin
      e = '0; e.kind = EV_ECC; exp_q.push_back(e);
    end else begin
      e = '0; e.kind = EV_HDR; e.short_pkt = (id[5:0] < 6'h10); e.id = id; e.wc = wc;
      exp_q.push_back(e);
      last_id = id; last_wc = wc;
      if (id[5:0] == 6'h00) exp_frame = 1'b1;
      if (id[5:0] == 6'h01) exp_frame = 1'b0;
      if (id[5:0] >= 6'h10 && wc != 0) begin
        need = (int'(wc) + 3) / 4;
        for (int b = 0; b < need && b < ncyc; b++) begin
          e = '0; e.kind = EV_BEAT; e.last = (b == need - 1);
          for (int k = 0; k < 4; k++) begin
            if (4*b + k < int'(wc)) begin
              wb = (4*b + k < body.size()) ? body[4*b + k] : 8'hFF;
              e.data[8*k +: 8] = wb;
              e.en[k] = 1'b1;
            end
          end
          exp_q.push_back(e);
        end
        if (ncyc < need) begin e = '0; e.kind = EV_TRUNC; exp_q.push_back(e); end
      end
    end
  endtask

  function automatic byte_q_t rand_bytes(input int n);
    byte_q_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  task automatic test_reset();
    reset_i = 1'b1; rx_valid_hs_i = '0; rx_data_hs_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    n_vec++;
    if ({header_valid_o, short_pkt_o, data_id_o, word_count_o, payload_valid_o, payload_data_o,
         payload_byte_en_o, payload_last_o, frame_active_o, err_ecc_o, err_lane_align_o,
         err_truncated_o} !== '0) begin
      n_err++; $display("FAIL reset_outputs: outputs not all zero during reset (hv=%b id=%h fa=%b)",
                        header_valid_o, data_id_o, frame_active_o);
    end
    @(negedge clk_i); reset_i = 1'b0;
    idle_cycles(2);
    n_vec++;
    if ({header_valid_o, data_id_o, word_count_o, payload_valid_o, frame_active_o} !== '0) begin
      n_err++; $display("FAIL reset_release: outputs moved with idle input (id=%h wc=%h fa=%b)",
                        data_id_o, word_count_o, frame_active_o);
    end
  endtask

  task automatic test_frame_markers();
    byte_q_t fill;
    for (int i = 0; i < 12; i++) fill.push_back(8'hFF);
    send_pkt({2'b00, DT_FSC}, 16'h0000, 8'h00, fill, 3);
    n_vec++;
    if (frame_active_o !== 1'b1) begin
      n_err++; $display("FAIL frame_start: frame_active_o=%b expected 1", frame_active_o);
    end
    fill.delete();
    send_pkt({2'b00, DT_FEC}, 16'h0000, 8'h00, fill, 3);
    n_vec++;
    if (frame_active_o !== 1'b0) begin
      n_err++; $display("FAIL frame_end: frame_active_o=%b expected 0", frame_active_o);
    end
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL frame_events count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_vec++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL frame_event[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_long_packets();
    byte_q_t body;
    body = rand_bytes(512);
    for (int i = 0; i < 80; i++) body.push_back(8'hFF);
    send_pkt({2'b00, DT_RAW8}, 16'd512, 8'h00, body, 3);
    body = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    send_pkt({2'b01, DT_RAW10}, 16'd6, 8'h00, body, 3);
    body.delete();
    send_pkt({2'b10, DT_RAW8}, 16'd0, 8'h00, body, 2);
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL long_events count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_vec++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL long_event[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_errors();
    byte_q_t body;
    body = rand_bytes(520);
    send_pkt({2'b00, DT_RAW8}, 16'd512, 8'h08, body, 3);
    n_vec++;
    if ({data_id_o, word_count_o} !== {last_id, last_wc}) begin
      n_err++; $display("FAIL ecc_hold: id/wc=%h/%h expected %h/%h", data_id_o, word_count_o, last_id, last_wc);
    end
    send_pkt({2'b00, DT_RAW10}, 16'd16, 8'hC0, rand_bytes(16), 2);
    send_pkt({2'b00, DT_RAW8}, 16'd512, 8'h00, rand_bytes(40), 3);
    // Lane 0 comes up one cycle after the other lanes.
    @(posedge clk_i); #1;
    rx_valid_hs_i = 4'b1110; rx_data_hs_i = {8'h2A, 8'h08, 8'h00, 8'h00};
    repeat (2) begin @(posedge clk_i); #1; rx_valid_hs_i = 4'hF; end
    idle_cycles(3);
    mon_e = '0; mon_e.kind = EV_ALIGN; exp_q.push_back(mon_e);
    send_pkt({2'b11, DT_RAW8}, 16'd9, 8'h00, rand_bytes(12), 3);
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL error_events count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_vec++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL error_event[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid();
    byte_q_t none;
    send_pkt({2'b00, DT_FSC}, 16'h0000, 8'h00, none, 2);
    @(posedge clk_i); #1;
    rx_valid_hs_i = 4'hF;
    rx_data_hs_i  = {8'h2A, 8'd64, 8'd0, {2'b00, ref_ecc({16'd64, 8'h2A})}};
    repeat (5) begin @(posedge clk_i); #1; rx_data_hs_i = 32'($urandom); end
    @(posedge clk_i); #2;
    reset_i = 1'b1;
    #1;
    n_vec++;
    if ({header_valid_o, short_pkt_o, data_id_o, word_count_o, payload_valid_o, payload_data_o,
         payload_byte_en_o, payload_last_o, frame_active_o, err_ecc_o, err_lane_align_o,
         err_truncated_o} !== '0) begin
      n_err++; $display("FAIL reset_mid_outputs: pv=%b data=%h fa=%b id=%h expected all zero",
                        payload_valid_o, payload_data_o, frame_active_o, data_id_o);
    end
    rx_valid_hs_i = '0; rx_data_hs_i = '0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i); reset_i = 1'b0;
    obs_q.delete(); exp_q.delete();
    exp_frame = 1'b0; last_id = '0; last_wc = '0;
    send_pkt({2'b00, DT_RAW10}, 16'd11, 8'h00, rand_bytes(11), 3);
    n_vec++;
    if (frame_active_o !== exp_frame) begin
      n_err++; $display("FAIL reset_mid_frame: frame_active_o=%b expected %b", frame_active_o, exp_frame);
    end
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL reset_mid_events count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_vec++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL reset_mid_event[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back();
    int kind, need;
    logic [7:0]  id;
    logic [15:0] wc;
    for (int p = 0; p < 60; p++) begin
      kind = int'($urandom_range(0, 9));
      id   = {2'($urandom), 6'($urandom_range(16, 63))};
      wc   = 16'($urandom_range(0, 40));
      case (kind)
        0, 1: send_pkt({2'($urandom), 6'($urandom_range(0, 15))}, 16'($urandom), 8'h00,
                       rand_bytes(int'($urandom_range(0, 8))), int'($urandom_range(1, 2)));
        2: send_pkt(id, wc, 8'(1 << $urandom_range(0, 5)), rand_bytes(int'(wc) + 2),
                    int'($urandom_range(1, 2)));
        3: begin
          wc   = 16'($urandom_range(5, 40));
          need = (int'(wc) + 3) / 4;
          send_pkt(id, wc, 8'h00, rand_bytes(4 * int'($urandom_range(0, need - 1))),
                   int'($urandom_range(1, 2)));
        end
        default: send_pkt(id, wc, 8'h00, rand_bytes(int'(wc) + 4 * int'($urandom_range(0, 2))),
                          int'($urandom_range(1, 2)));
      endcase
    end
    idle_cycles(2);
    n_vec++;
    if (frame_active_o !== exp_frame) begin
      n_err++; $display("FAIL b2b_frame: frame_active_o=%b expected %b", frame_active_o, exp_frame);
    end
    n_vec++;
    if ({data_id_o, word_count_o} !== {last_id, last_wc}) begin
      n_err++; $display("FAIL b2b_last_header: id/wc=%h/%h expected %h/%h", data_id_o, word_count_o, last_id, last_wc);
    end
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL b2b_events count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_vec++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL b2b_event[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_frame_markers();
    test_long_packets();
    test_errors();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
